gf233_reduce: RTL

GF233_REDUCE -- requirements
Module: gf233_reduce

---
 rtl/gf233_pkg.sv | 7 +
 rtl/gf233_fold.sv | 14 +
 rtl/gf233_reduce.sv | 49 ++++
 3 files changed

// File: rtl/gf233_pkg.sv
// gf233_pkg: shared GF(2^233) field constants and reducer FSM states
package gf233_pkg;
    localparam int GF_N = 233;
    localparam int GF_K = 74;
    localparam int GF_W = 2*GF_N-1;
    typedef enum logic [1:0] {IDLE, FOLD1, FOLD2, OUT} state_t;
endpackage

// File: rtl/gf233_fold.sv
// gf233_fold: one trinomial fold step, low ^ H ^ (H << K) with H the upper half
module gf233_fold
    import gf233_pkg::*;
#(
    parameter int N = GF_N,
    parameter int K = GF_K
) (
    input  logic [2*N-2:0] a,
    output logic [2*N-2:0] y
);
    logic [2*N-2:0] h;
    assign h = {{N{1'b0}}, a[2*N-2:N]};
    assign y = {{(N-1){1'b0}}, a[N-1:0]} ^ h ^ (h << K);
endmodule

// File: rtl/gf233_reduce.sv
// gf233_reduce: reduces a 2N-1 bit GF(2) product modulo x^N + x^K + 1 in two fold cycles
module gf233_reduce
    import gf233_pkg::*;
#(
    parameter int N = GF_N,
    parameter int K = GF_K
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [2*N-2:0] c_in,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [N-1:0]   r_out,
    output logic           out_valid,
    input  logic           out_ready
);
    state_t         state, state_nx;
    logic [2*N-2:0] acc, acc_nx, fold_acc;

    gf233_fold #(.N(N), .K(K)) u_fold (.a(acc), .y(fold_acc));

    // next state and accumulator: load in IDLE, fold in FOLD1/FOLD2, hold in OUT
    always_comb begin
        state_nx = state;
        acc_nx   = (state == FOLD1 || state == FOLD2) ? fold_acc :
                   (state == IDLE && in_valid)        ? c_in : acc;
        case (state)
            IDLE:    state_nx = in_valid ? FOLD1 : IDLE;
            FOLD1:   state_nx = FOLD2;
            FOLD2:   state_nx = OUT;
            default: state_nx = out_ready ? IDLE : OUT;
        endcase
    end

    // state and accumulator registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign r_out     = acc[N-1:0];
endmodule
